piso_tx_sequencer: RTL and testbench

Controller that sequences the 10-bit parallel-in/serial-out shift register. It accepts parallel words over a valid/ready handshake, issues the shifter's load strobe, and paces the shift-enable (SRControl) at a programmable bit period so that the MSB-first serial stream on the shifter's sOut holds each bit for DIV clocks. It sits between the word source (CPU/bus side) and the shifter, and reports busy, active-window and completion status.

---
 rtl/piso_seq_pkg.sv | 19 +
 rtl/piso_bit_timer.sv | 39 +++
 rtl/piso_tx_sequencer.sv | 113 +++++++++++
 tb/tb_piso_tx_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_seq_pkg.sv
// Shared types and defaults for the PISO transmit sequencer and its bit timer.
package piso_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int   DEF_WIDTH = 10;
  localparam int   DEF_DIV   = 4;
  localparam logic DEF_FILL  = 1'b1;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Modulo-DIV bit-period counter with synchronous clear.
// tc marks the last clock of a bit period; tc_next predicts it one cycle ahead.
module piso_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc,
  output logic tc_next
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tc      = en && (cnt == LAST);
  // Lets the sequencer register sh_shift so it lands in the terminal cycle.
  assign tc_next = (cnt_nxt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/piso_tx_sequencer.sv
// Sequences load and paced shift strobes for a WIDTH-bit PISO shifter, MSB first,
// each bit held DIV clocks; one word per WIDTH*DIV+3 cycles, valid/ready on input.
module piso_tx_sequencer
  import piso_seq_pkg::*;
#(
  parameter int   WIDTH = DEF_WIDTH,
  parameter int   DIV   = DEF_DIV,
  parameter logic FILL  = DEF_FILL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic                          abort,
  output logic [WIDTH-1:0]              sh_data,
  output logic                          sh_load,
  output logic                          sh_shift,
  output logic                          sh_sIn,
  output logic                          tx_active,
  output logic                          busy,
  output logic                          done,
  output logic [idx_width(WIDTH)-1:0]   bit_idx
);

  localparam int            IW       = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  seq_state_t    state;
  logic          tc;
  logic          tc_next;
  logic          tmr_clear;
  logic [IW-1:0] idx_inc;

  assign in_ready  = (state == IDLE) && !rst;
  assign sh_sIn    = FILL;
  assign tmr_clear = (state != SHIFT) || abort;
  assign idx_inc   = bit_idx + IW'(1);

  piso_bit_timer #(.DIV(DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (state == SHIFT),
    .tc      (tc),
    .tc_next (tc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh_data   <= '0;
      sh_load   <= 1'b0;
      sh_shift  <= 1'b0;
      tx_active <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
    end else begin
      sh_load  <= 1'b0;
      sh_shift <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !abort) begin
            sh_data <= in_data;
            sh_load <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          bit_idx <= '0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tx_active <= 1'b1;
            sh_shift  <= tc_next;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            tx_active <= 1'b0;
            busy      <= 1'b0;
            bit_idx   <= '0;
            state     <= IDLE;
          end else if (tc) begin
            if (bit_idx == LAST_IDX) begin
              tx_active <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              bit_idx  <= idx_inc;
              sh_shift <= tc_next && (idx_inc != LAST_IDX);
            end
          end else begin
            // The last bit period ends the word without shifting it out.
            sh_shift <= tc_next && (bit_idx != LAST_IDX);
          end
        end
        DONE: begin
          busy    <= 1'b0;
          bit_idx <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// Directed bench: DIV=4 and DIV=1 sequencers each driving a PISO shifter model.
module tb_piso_tx_sequencer;
  import piso_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, abort = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_ready, sh_load, sh_shift, sh_sin, tx_active, busy, done;
  logic [9:0] sh_data;
  logic [3:0] bit_idx;

  logic       v1 = 1'b0, a1 = 1'b0;
  logic [9:0] d1 = '0;
  logic       rdy1, load1, shift1, sin1, txa1, busy1, done1;
  logic [9:0] shd1;
  logic [3:0] idx1;

  logic [9:0] sr, sr1;
  logic       sout, sout1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_tx_sequencer #(.WIDTH(10), .DIV(4), .FILL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .sh_data(sh_data), .sh_load(sh_load), .sh_shift(sh_shift),
    .sh_sIn(sh_sin), .tx_active(tx_active), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  piso_tx_sequencer #(.WIDTH(10), .DIV(1), .FILL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .abort(a1), .sh_data(shd1), .sh_load(load1), .sh_shift(shift1),
    .sh_sIn(sin1), .tx_active(txa1), .busy(busy1), .done(done1), .bit_idx(idx1)
  );

  // Shifter models: load wins, shift moves toward the MSB, fill enters at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      sr1 <= '0;
    end else begin
      if (sh_load) sr <= sh_data;
      else if (sh_shift) sr <= {sr[8:0], sh_sin};
      if (load1) sr1 <= shd1;
      else if (shift1) sr1 <= {sr1[8:0], sin1};
    end
  end
  assign sout  = sr[9];
  assign sout1 = sr1[9];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:9] exp2;
    logic [0:9] exp5;
    int nshift, last_shift, ndone, done_t;
    exp2 = 10'b1000010100;
    exp5 = 10'b1010101010;

    // Reset state
    step(); step();
    chk("rst_rdy", in_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", in_ready, 1);
    chk("idle_data", sh_data, 0);
    chk("idle_idx", bit_idx, 0);

    // Single word, DIV=4
    in_data = 10'b1000010100;
    in_valid = 1'b1;
    chk("t0_rdy", in_ready, 1);
    nshift = 0;
    for (int t = 1; t <= 43; t++) begin
      step();
      if (t == 1) in_valid = 1'b0;
      chk($sformatf("load@T%0d", t), sh_load, (t == 1));
      chk($sformatf("shift@T%0d", t), sh_shift, (t >= 5 && t <= 37 && (t - 5) % 4 == 0));
      chk($sformatf("done@T%0d", t), done, (t == 42));
      chk($sformatf("txa@T%0d", t), tx_active, (t >= 2 && t <= 41));
      chk($sformatf("rdy@T%0d", t), in_ready, (t >= 43));
      if (t >= 2 && t <= 41) chk($sformatf("sout@T%0d", t), sout, exp2[(t - 2) / 4]);
      if (t == 6)  chk("idx@T6", bit_idx, 1);
      if (t == 41) chk("idx@T41", bit_idx, 9);
      if (t >= 1 && t <= 42) chk($sformatf("busy@T%0d", t), busy, 1);
      if (sh_load && sh_shift) chk("load_and_shift", 1, 0);
      nshift += sh_shift;
    end
    chk("shift_count", nshift, 9);

    // Back-to-back words with in_valid held
    in_data = 10'h3FF;
    in_valid = 1'b1;
    for (int t = 1; t <= 44; t++) begin
      step();
      if (t == 1) in_data = 10'h001;
      if (t == 2)  chk("b2b_data_held", sh_data, 10'h3FF);
      if (t == 42) chk("b2b_rdy42", in_ready, 0);
      if (t == 43) chk("b2b_rdy43", in_ready, 1);
      if (t == 43) chk("b2b_load43", sh_load, 0);
      if (t == 44) begin
        chk("b2b_load44", sh_load, 1);
        chk("b2b_data44", sh_data, 10'h001);
        in_valid = 1'b0;
      end
    end
    done_t = 0;
    for (int t = 45; t <= 90; t++) begin
      step();
      if (done && done_t == 0) done_t = t;
    end
    chk("b2b_done_t", done_t, 85);

    // Abort mid-SHIFT
    in_data = 10'h155;
    in_valid = 1'b1;
    last_shift = 0;
    for (int t = 1; t <= 16; t++) begin
      step();
      if (t == 1) in_valid = 1'b0;
      if (sh_shift) last_shift = t;
      if (t == 15) abort = 1'b1;
    end
    abort = 1'b0;
    chk("abort_rdy", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_txa", tx_active, 0);
    chk("abort_idx", bit_idx, 0);
    chk("abort_data_held", sh_data, 10'h155);
    ndone = 0;
    for (int t = 17; t <= 60; t++) begin
      step();
      if (sh_shift) last_shift = t;
      ndone += done;
    end
    chk("abort_last_shift", last_shift, 13);
    chk("abort_no_done", ndone, 0);

    // Async reset mid-SHIFT
    in_data = 10'h2C3;
    in_valid = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (t == 1) in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("arst_data", sh_data, 0);
    chk("arst_txa", tx_active, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", bit_idx, 0);
    chk("arst_shift", sh_shift, 0);
    chk("arst_rdy", in_ready, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("arst_rdy_release", in_ready, 1);
    ndone = 0;
    for (int t = 0; t < 50; t++) begin
      step();
      ndone += done;
    end
    chk("arst_no_done", ndone, 0);

    // DIV=1 instance
    d1 = 10'h2AA;
    v1 = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      step();
      if (t == 1) v1 = 1'b0;
      chk($sformatf("d1_shift@T%0d", t), shift1, (t >= 2 && t <= 10));
      chk($sformatf("d1_done@T%0d", t), done1, (t == 12));
      if (t >= 2 && t <= 11) chk($sformatf("d1_sout@T%0d", t), sout1, exp5[t - 2]);
    end
    chk("d1_rdy", rdy1, 1);

    // in_valid with abort in IDLE
    in_data = 10'h0F0;
    in_valid = 1'b1;
    abort = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      step();
      chk($sformatf("va_load@%0d", t), sh_load, 0);
      chk($sformatf("va_busy@%0d", t), busy, 0);
      chk($sformatf("va_rdy@%0d", t), in_ready, 1);
    end
    in_valid = 1'b0;
    abort = 1'b0;
    step();
    chk("va_idle_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
